// File: rtl/i2s_tx_ctrl_pkg.sv
// Shared constants and types for the I2S transmit path (controller, clock
// generator and serializer).
package i2s_pkg;

  localparam int DEF_DATA_BIT = 16;
  localparam int DEF_DIV      = 8;
  localparam int FRAME_BITS   = 2 * DEF_DATA_BIT;

  typedef struct packed {
    logic [DEF_DATA_BIT-1:0] left;
    logic [DEF_DATA_BIT-1:0] right;
  } sample_t;

  function automatic int frame_bits(input int data_bit);
    return 2 * data_bit;
  endfunction

endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// Upstream stereo sample stream: valid/ready handshake carrying one L/R pair.
interface i2s_tx_ctrl_if
  import i2s_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT
) ();

  logic                s_valid;
  logic                s_ready;
  logic [DATA_BIT-1:0] s_audio_l;
  logic [DATA_BIT-1:0] s_audio_r;

  modport master (output s_valid, output s_audio_l, output s_audio_r, input s_ready);
  modport slave  (input s_valid, input s_audio_l, input s_audio_r, output s_ready);

endinterface

// File: rtl/i2s_tx_ctrl_clk_gen.sv
// Divides the audio clock into bclk/lrclk and produces the serializer's
// load (tx_rd_en) and shift (tx_sclk) strobes at each bit boundary.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int DIV      = DEF_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic bclk_o,
  output logic lrclk_o,
  output logic tx_rd_en_o,
  output logic tx_sclk_o
);

  localparam int FB = frame_bits(DATA_BIT);
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(FB);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);
  localparam logic [BW-1:0] LR_LO    = BW'(DATA_BIT - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(FB - 2);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          bit_bnd;

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    bit_bnd = 1'b0;
    if (enable_i) begin
      bit_bnd = (div_q == DIV_LAST);
      if (bit_bnd) begin
        div_d = '0;
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = '0;
      bit_d = BIT_LAST;
    end
    // Pins are registered from next-state so they line up with the counters.
    bclk_d  = (div_d >= DIV_HALF);
    lrclk_d = enable_i && (bit_d >= LR_LO) && (bit_d <= LR_HI);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      bit_q   <= BIT_LAST;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign tx_rd_en_o = bit_bnd & (bit_q == BIT_LAST);
  assign tx_sclk_o  = bit_bnd & (bit_q != BIT_LAST);

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: timing generation, one-entry stereo sample buffer,
// silence substitution and saturating underrun counting.
module i2s_tx_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int DIV      = DEF_DIV,
  parameter int UCNT_W   = 16
) (
  input  logic                clk_12_288,
  input  logic                reset,
  input  logic                enable,
  i2s_tx_ctrl_if.slave        s_if,
  output logic                bclk,
  output logic                lrclk,
  output logic                tx_rd_en,
  output logic                tx_sclk,
  output logic [DATA_BIT-1:0] tx_audio_l,
  output logic [DATA_BIT-1:0] tx_audio_r,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  input  logic                underrun_clr
);

  logic                buf_full_q, buf_full_d;
  logic [DATA_BIT-1:0] buf_l_q, buf_l_d;
  logic [DATA_BIT-1:0] buf_r_q, buf_r_d;
  logic                underrun_q, underrun_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                s_ready;
  logic                hs;

  i2s_clk_gen #(
    .DATA_BIT (DATA_BIT),
    .DIV      (DIV)
  ) u_clk_gen (
    .clk_i      (clk_12_288),
    .rst_i      (reset),
    .enable_i   (enable),
    .bclk_o     (bclk),
    .lrclk_o    (lrclk),
    .tx_rd_en_o (tx_rd_en),
    .tx_sclk_o  (tx_sclk)
  );

  assign s_ready     = enable & ~buf_full_q;
  assign hs          = s_if.s_valid & s_ready;
  assign s_if.s_ready = s_ready;

  always_comb begin
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    // A load empties the buffer; a same-cycle handshake refills it for the next frame.
    if (!enable) begin
      buf_full_d = 1'b0;
    end else if (tx_rd_en) begin
      buf_full_d = hs;
    end else if (hs) begin
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end
    if (hs) begin
      buf_l_d = s_if.s_audio_l;
      buf_r_d = s_if.s_audio_r;
    end else begin
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
    end
    if (tx_rd_en && !buf_full_q) begin
      underrun_d = 1'b1;
      if (ucnt_q != '1) begin
        ucnt_d = ucnt_q + UCNT_W'(1);
      end else begin
        ucnt_d = ucnt_q;
      end
    end else begin
      underrun_d = 1'b0;
    end
    if (underrun_clr) begin
      ucnt_d = '0;
    end else begin
      ucnt_d = ucnt_d;
    end
  end

  always_ff @(posedge clk_12_288 or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign tx_audio_l   = buf_full_q ? buf_l_q : '0;
  assign tx_audio_r   = buf_full_q ? buf_r_q : '0;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule
